// File: rtl/noc_mux2_pkg.sv
// Router-wide shared definitions: flit type codes, default widths, polarity constants.
// Latency: n/a (constants only).
// Backpressure: n/a (constants only).
package noc_mux2_pkg;

    // Default datapath widths
    localparam int DATA_W = 67;
    localparam int VCH_W  = 2;
    localparam int PORT_W = 5;
    localparam int TYPE_W = 3;

    // Flit type codes carried in the top TYPE_W bits of a flit
    localparam logic [TYPE_W-1:0] TYPE_NONE = 3'd0;
    localparam logic [TYPE_W-1:0] TYPE_HEAD = 3'd1;
    localparam logic [TYPE_W-1:0] TYPE_DATA = 3'd2;
    localparam logic [TYPE_W-1:0] TYPE_TAIL = 3'd3;

    // Level and polarity constants; the trailing underscore marks active-low forms
    localparam logic High     = 1'b1;
    localparam logic Low      = 1'b0;
    localparam logic Enable   = 1'b1;
    localparam logic Disable  = 1'b0;
    localparam logic Enable_  = 1'b0;
    localparam logic Disable_ = 1'b1;

endpackage

// File: rtl/noc_mux2.sv
// Two-input flit mux selected by a one-hot port vector; illegal selects output zeros.
// Latency: 1 cycle, outputs come straight from flops.
// Backpressure: none; the downstream side always accepts.
module noc_mux2
    import noc_mux2_pkg::*;
#(
    parameter int DATA_W = noc_mux2_pkg::DATA_W,
    parameter int VCH_W  = noc_mux2_pkg::VCH_W,
    parameter int PORT_W = noc_mux2_pkg::PORT_W
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic [DATA_W-1:0] idata_0,
    input  logic              ivalid_0,
    input  logic [VCH_W-1:0]  ivch_0,
    input  logic [DATA_W-1:0] idata_1,
    input  logic              ivalid_1,
    input  logic [VCH_W-1:0]  ivch_1,
    input  logic [PORT_W-1:0] sel,
    output logic [DATA_W-1:0] odata,
    output logic              ovalid,
    output logic [VCH_W-1:0]  ovch
);

    // Only these two exact codes are legal; reserved bits must be clear
    localparam logic [PORT_W-1:0] SEL_P0 = PORT_W'(1);
    localparam logic [PORT_W-1:0] SEL_P1 = PORT_W'(2);

    logic [DATA_W-1:0] nxt_data;
    logic              nxt_valid;
    logic [VCH_W-1:0]  nxt_vch;

    // Select decode; data and vch pass through even when valid is low so the
    // output toggling reflects the raw input activity
    always_comb begin
        nxt_data  = '0;
        nxt_valid = Low;
        nxt_vch   = '0;
        if (sel == SEL_P0) begin
            nxt_data  = idata_0;
            nxt_valid = ivalid_0;
            nxt_vch   = ivch_0;
        end else if (sel == SEL_P1) begin
            nxt_data  = idata_1;
            nxt_valid = ivalid_1;
            nxt_vch   = ivch_1;
        end
    end

    // Output register bank; reset clears it immediately and drops any in-flight flit
    always_ff @(posedge clk or negedge rst_) begin
        if (rst_ == Enable_) begin
            odata  <= '0;
            ovalid <= Low;
            ovch   <= '0;
        end else begin
            odata  <= nxt_data;
            ovalid <= nxt_valid;
            ovch   <= nxt_vch;
        end
    end

endmodule

// File: tb/tb_noc_mux2.sv
// Directed bench for noc_mux2 with hand-computed expectations.
module tb_noc_mux2;
    import noc_mux2_pkg::*;

    logic        clk = 1'b0;
    logic        rst_;
    logic [66:0] idata_0;
    logic        ivalid_0;
    logic [1:0]  ivch_0;
    logic [66:0] idata_1;
    logic        ivalid_1;
    logic [1:0]  ivch_1;
    logic [4:0]  sel;
    logic [66:0] odata;
    logic        ovalid;
    logic [1:0]  ovch;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    noc_mux2 dut (
        .clk      (clk),
        .rst_     (rst_),
        .idata_0  (idata_0),
        .ivalid_0 (ivalid_0),
        .ivch_0   (ivch_0),
        .idata_1  (idata_1),
        .ivalid_1 (ivalid_1),
        .ivch_1   (ivch_1),
        .sel      (sel),
        .odata    (odata),
        .ovalid   (ovalid),
        .ovch     (ovch)
    );

    task automatic check(input string tag, input logic [66:0] got, input logic [66:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge and settle away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".odata"},  odata,          67'h0);
        check({tag, ".ovalid"}, 67'(ovalid),    67'h0);
        check({tag, ".ovch"},   67'(ovch),      67'h0);
    endtask

    // Drive one flit on port 1 while port 0 carries unrelated traffic,
    // then expect exactly the port-1 flit one edge later
    task automatic send_p1(input string tag, input logic [66:0] flit, input logic [1:0] vch);
        idata_1  = flit;
        ivalid_1 = 1'b1;
        ivch_1   = vch;
        idata_0  = {TYPE_TAIL, 32'(~$urandom), 32'($urandom)};
        ivalid_0 = 1'b1;
        ivch_0   = ~vch;
        step();
        check({tag, ".odata"},  odata,       flit);
        check({tag, ".ovalid"}, 67'(ovalid), 67'h1);
        check({tag, ".ovch"},   67'(ovch),   67'(vch));
    endtask

    logic [66:0] flit;
    logic [4:0]  bad_sel [3];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bad_sel[0] = 5'b00000;
        bad_sel[1] = 5'b00011;
        bad_sel[2] = 5'b00100;

        // Reset with non-zero inputs and port 1 selected
        rst_     = 1'b0;
        idata_0  = {TYPE_DATA, 64'hAAAA_5555_AAAA_5555};
        ivalid_0 = 1'b1;
        ivch_0   = 2'd1;
        idata_1  = {TYPE_HEAD, 64'h0123_4567_89AB_CDEF};
        ivalid_1 = 1'b1;
        ivch_1   = 2'd3;
        sel      = 5'b00010;
        #2;
        check_zero("rst_async");
        step();
        step();
        check_zero("rst_hold");
        rst_ = 1'b1;
        step();
        check("rst_release.odata",  odata,       {TYPE_HEAD, 64'h0123_4567_89AB_CDEF});
        check("rst_release.ovalid", 67'(ovalid), 67'h1);
        check("rst_release.ovch",   67'(ovch),   67'h3);

        // Port 1 stream: head, 20 random data flits, tail
        sel = 5'b00010;
        send_p1("p1_head", {TYPE_HEAD, 32'h0, 32'h04}, 2'd1);
        for (int i = 0; i < 20; i++) begin
            send_p1("p1_data", {TYPE_DATA, 32'($urandom), 32'($urandom)}, 2'(i));
        end
        send_p1("p1_tail", {TYPE_TAIL, 32'h0, 32'hFEED}, 2'd1);

        // Outputs must not follow an input change until the next edge
        idata_1 = {TYPE_DATA, 64'h1111_2222_3333_4444};
        #2;
        check("no_comb_path", odata, {TYPE_TAIL, 32'h0, 32'hFEED});

        // Port 0 head on vc 2 while port 1 shows something else
        sel      = 5'b00001;
        idata_0  = {TYPE_HEAD, 32'h0, 32'h09};
        ivalid_0 = 1'b1;
        ivch_0   = 2'd2;
        ivch_1   = 2'd1;
        step();
        check("p0_head.odata",  odata,       {TYPE_HEAD, 32'h0, 32'h09});
        check("p0_head.ovalid", 67'(ovalid), 67'h1);
        check("p0_head.ovch",   67'(ovch),   67'h2);

        // Invalid flit bits still pass through
        sel      = 5'b00010;
        ivalid_1 = 1'b0;
        idata_1  = 67'h7FFF;
        ivch_1   = 2'd3;
        step();
        check("inv_pass.odata",  odata,       67'h7FFF);
        check("inv_pass.ovalid", 67'(ovalid), 67'h0);
        check("inv_pass.ovch",   67'(ovch),   67'h3);

        // Illegal selects, each preceded by a legal cycle with non-zero output
        for (int i = 0; i < 3; i++) begin
            sel      = 5'b00010;
            idata_0  = {TYPE_DATA, 64'hC0DE_0000_0000_0000} | 67'(i);
            ivalid_0 = 1'b1;
            ivch_0   = 2'd2;
            idata_1  = {TYPE_DATA, 64'hBEEF_0000_0000_0000} | 67'(i);
            ivalid_1 = 1'b1;
            ivch_1   = 2'd1;
            step();
            check("pre_illegal.odata", odata, {TYPE_DATA, 64'hBEEF_0000_0000_0000} | 67'(i));
            sel = bad_sel[i];
            step();
            check_zero("illegal_sel");
        end

        // Mid-packet reset during the 5th data flit
        sel = 5'b00010;
        send_p1("mp_head", {TYPE_HEAD, 32'h0, 32'h04}, 2'd2);
        for (int i = 0; i < 4; i++) begin
            send_p1("mp_data", {TYPE_DATA, 32'h0, 32'(i + 1)}, 2'd2);
        end
        idata_1 = {TYPE_DATA, 32'h0, 32'h5};
        #2;
        rst_ = 1'b0;
        #1;
        check_zero("mp_rst_now");
        step();
        step();
        check_zero("mp_rst_hold");
        rst_ = 1'b1;
        step();
        check("mp_release.odata", odata, {TYPE_DATA, 32'h0, 32'h5});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
